// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/clear sequencer with lap capture, display hold and lap recall
module stopwatch_ctrl #(
  parameter int LAP_DEPTH  = 4,
  parameter int HOLD_TICKS = 100_000_000,
  parameter int BITS       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_p,
  input  logic                           stop_p,
  input  logic                           reset_p,
  input  logic                           lap_p,
  input  logic [BITS-1:0]                time_in,
  output logic                           count_en,
  output logic                           count_clr,
  output logic [BITS-1:0]                disp_time,
  output logic                           disp_is_lap,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic [$clog2(LAP_DEPTH)-1:0]   recall_idx,
  output logic                           lap_ovf,
  output logic [1:0]                     state_o
);

  localparam int LCW = $clog2(LAP_DEPTH + 1);
  localparam int IW  = $clog2(LAP_DEPTH);
  localparam int HW  = $clog2(HOLD_TICKS + 1);
  localparam logic [LCW-1:0] LAP_FULL  = LCW'(LAP_DEPTH);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_RECALL = 2'd3
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold;
  logic [BITS-1:0] lap_mem [LAP_DEPTH];

  // Only the highest-priority pulse acts, even if it means nothing in this state.
  logic win_reset, win_stop, win_start, win_lap;
  assign win_reset = reset_p;
  assign win_stop  = stop_p & ~reset_p;
  assign win_start = start_p & ~stop_p & ~reset_p;
  assign win_lap   = lap_p & ~start_p & ~stop_p & ~reset_p;

  logic           full;
  logic           lap_wr;
  logic [LCW-1:0] last_idx;
  logic [IW-1:0]  next_idx;
  assign full     = (lap_count == LAP_FULL);
  assign lap_wr   = (state == S_RUN) && win_lap && !full;
  assign last_idx = lap_count - 1'b1;
  assign next_idx = (LCW'(recall_idx) == last_idx) ? '0 : recall_idx + 1'b1;

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (lap_wr) lap_mem[lap_count[IW-1:0]] <= time_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || win_reset) begin
      state       <= S_IDLE;
      count_en    <= 1'b0;
      count_clr   <= 1'b1;
      disp_time   <= '0;
      disp_is_lap <= 1'b0;
      lap_count   <= '0;
      recall_idx  <= '0;
      lap_ovf     <= 1'b0;
      hold        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_start) begin
            state     <= S_RUN;
            count_en  <= 1'b1;
            count_clr <= 1'b0;
            disp_time <= time_in;
          end
        end
        S_RUN: begin
          if (win_stop) begin
            state       <= S_PAUSE;
            count_en    <= 1'b0;
            hold        <= '0;
            disp_time   <= time_in;
            disp_is_lap <= 1'b0;
          end else if (lap_wr) begin
            lap_count   <= lap_count + 1'b1;
            hold        <= HOLD_LOAD;
            disp_time   <= time_in;
            disp_is_lap <= 1'b1;
          end else begin
            if (win_lap) lap_ovf <= 1'b1;
            // The last hold tick releases the display so the freeze lasts exactly HOLD_TICKS cycles.
            if (hold > HW'(1)) begin
              hold <= hold - 1'b1;
            end else begin
              hold        <= '0;
              disp_time   <= time_in;
              disp_is_lap <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (win_start) begin
            state     <= S_RUN;
            count_en  <= 1'b1;
            disp_time <= time_in;
          end else if (win_lap && lap_count != '0) begin
            state       <= S_RECALL;
            recall_idx  <= '0;
            disp_time   <= lap_mem[0];
            disp_is_lap <= 1'b1;
          end else begin
            disp_time <= time_in;
          end
        end
        S_RECALL: begin
          if (win_stop) begin
            state       <= S_PAUSE;
            recall_idx  <= '0;
            disp_time   <= time_in;
            disp_is_lap <= 1'b0;
          end else if (win_start) begin
            state       <= S_RUN;
            count_en    <= 1'b1;
            recall_idx  <= '0;
            disp_time   <= time_in;
            disp_is_lap <= 1'b0;
          end else if (win_lap) begin
            recall_idx <= next_idx;
            disp_time  <= lap_mem[next_idx];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed-vector bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_p = 1'b0;
  logic        stop_p = 1'b0;
  logic        reset_p = 1'b0;
  logic        lap_p = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic        count_en;
  logic        count_clr;
  logic [15:0] disp_time;
  logic        disp_is_lap;
  logic [2:0]  lap_count;
  logic [1:0]  recall_idx;
  logic        lap_ovf;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] P_NONE = 4'b0000, P_LAP = 4'b0001, P_START = 4'b0010,
                         P_STOP = 4'b0100, P_RESET = 4'b1000;

  stopwatch_ctrl #(.LAP_DEPTH(4), .HOLD_TICKS(8), .BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .stop_p(stop_p),
    .reset_p(reset_p), .lap_p(lap_p), .time_in(time_in),
    .count_en(count_en), .count_clr(count_clr), .disp_time(disp_time),
    .disp_is_lap(disp_is_lap), .lap_count(lap_count), .recall_idx(recall_idx),
    .lap_ovf(lap_ovf), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive {reset,stop,start,lap} for one edge, then sample 1 ns after it.
  task automatic step(input logic [3:0] p);
    {reset_p, stop_p, start_p, lap_p} = p;
    @(posedge clk);
    #1;
    {reset_p, stop_p, start_p, lap_p} = 4'b0000;
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_en"}, count_en, 0);
    check({tag, "_clr"}, count_clr, 1);
    check({tag, "_disp"}, disp_time, 16'h0000);
    check({tag, "_islap"}, disp_is_lap, 0);
    check({tag, "_lapcnt"}, lap_count, 0);
    check({tag, "_ridx"}, recall_idx, 0);
    check({tag, "_ovf"}, lap_ovf, 0);
  endtask

  logic [15:0] recall_exp [4];

  initial begin
    recall_exp[0] = 16'h0105;
    recall_exp[1] = 16'h0210;
    recall_exp[2] = 16'h0320;
    recall_exp[3] = 16'h0105;

    step(P_NONE);
    step(P_NONE);
    expect_reset("por");
    rst_n = 1'b1;

    time_in = 16'h0007;
    step(P_START);
    check("start_state", state_o, 1);
    check("start_en", count_en, 1);
    check("start_clr", count_clr, 0);
    check("start_disp", disp_time, 16'h0007);
    time_in = 16'h0008;
    step(P_NONE);
    check("track_disp", disp_time, 16'h0008);

    time_in = 16'h1234;
    step(P_LAP);
    check("lap_cnt1", lap_count, 1);
    check("lap_disp0", disp_time, 16'h1234);
    check("lap_islap0", disp_is_lap, 1);
    for (int i = 1; i < 8; i++) begin
      time_in = 16'h2000 + 16'(i);
      step(P_NONE);
      check($sformatf("hold_disp%0d", i), disp_time, 16'h1234);
      check($sformatf("hold_islap%0d", i), disp_is_lap, 1);
    end
    time_in = 16'h3000;
    step(P_NONE);
    check("release_disp", disp_time, 16'h3000);
    check("release_islap", disp_is_lap, 0);

    step(P_RESET | P_STOP);
    expect_reset("rst_stop");

    step(P_START);
    for (int k = 0; k < 5; k++) begin
      time_in = 16'h0100 + 16'(k);
      step(P_LAP);
    end
    check("ovf_cnt", lap_count, 4);
    check("ovf_flag", lap_ovf, 1);
    check("ovf_disp", disp_time, 16'h0103);
    time_in = 16'h0200;
    for (int i = 0; i < 6; i++) step(P_NONE);
    check("ovf_hold_last", disp_time, 16'h0103);
    step(P_NONE);
    check("ovf_release", disp_time, 16'h0200);
    check("ovf_release_islap", disp_is_lap, 0);
    step(P_STOP);
    check("ovf_sticky", lap_ovf, 1);

    step(P_RESET);
    check("ovf_cleared", lap_ovf, 0);
    step(P_START);
    time_in = 16'h0105; step(P_LAP);
    time_in = 16'h0150; step(P_NONE);
    time_in = 16'h0210; step(P_LAP);
    time_in = 16'h0250; step(P_NONE);
    time_in = 16'h0320; step(P_LAP);
    time_in = 16'h0350; step(P_NONE);
    check("three_laps", lap_count, 3);
    time_in = 16'h0400;
    step(P_STOP);
    check("pause_state", state_o, 2);
    check("pause_en", count_en, 0);
    check("pause_disp", disp_time, 16'h0400);
    check("pause_islap", disp_is_lap, 0);
    step(P_STOP | P_START);
    check("stop_start_pause", state_o, 2);
    for (int i = 0; i < 4; i++) begin
      step(P_LAP);
      check($sformatf("recall_state%0d", i), state_o, 3);
      check($sformatf("recall_disp%0d", i), disp_time, recall_exp[i]);
      check($sformatf("recall_idx%0d", i), recall_idx, (i == 3) ? 0 : i);
      check($sformatf("recall_islap%0d", i), disp_is_lap, 1);
    end
    step(P_STOP);
    check("recall_stop_state", state_o, 2);
    check("recall_stop_disp", disp_time, 16'h0400);
    step(P_START);
    check("resume_state", state_o, 1);
    check("laps_survive", lap_count, 3);

    step(P_RESET);
    step(P_START);
    step(P_STOP);
    step(P_LAP);
    check("empty_recall_state", state_o, 2);
    check("empty_recall_islap", disp_is_lap, 0);

    step(P_START);
    time_in = 16'h0777;
    step(P_LAP);
    check("midhold_islap", disp_is_lap, 1);
    rst_n = 1'b0;
    step(P_NONE);
    expect_reset("rst_hold");
    rst_n = 1'b1;

    step(P_START);
    step(P_LAP);
    step(P_LAP);
    step(P_STOP);
    step(P_LAP);
    step(P_LAP);
    check("pre_rst_recall_state", state_o, 3);
    check("pre_rst_recall_idx", recall_idx, 1);
    rst_n = 1'b0;
    step(P_LAP);
    expect_reset("rst_recall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
